ubbe_ledseq: RTL

UBBE_LEDSEQ -- requirements
Module: ubbe_ledseq

---
 rtl/ubbe_pkg.sv | 20 ++
 rtl/ubbe_debounce.sv | 53 +++++
 rtl/ubbe_ledseq.sv | 113 +++++++++++
 3 files changed

// File: rtl/ubbe_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, scanner states, widths.
package ubbe_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DEB_W  = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_WALK = 2'd2,
        MODE_SCAN = 2'd3
    } mode_t;

    typedef enum logic {
        SCAN_UP   = 1'b0,
        SCAN_DOWN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/ubbe_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stable-count debouncer and
// a one-cycle pulse on each accepted 0->1 transition.
module ubbe_debounce
    import ubbe_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic             sync_q1;
    logic             sync_q2;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             dout_d;
    logic             rise_d;

    // Count consecutive cycles the synchronised input disagrees with the level.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout;
        rise_d = 1'b0;
        if (sync_q2 != dout) begin
            if ((32'(cnt_q) + 32'd1) >= DEB_CYCLES) begin
                dout_d = sync_q2;
                rise_d = sync_q2;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            dout    <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            cnt_q   <= cnt_d;
            dout    <= dout_d;
            rise    <= rise_d;
        end
    end

endmodule

// File: rtl/ubbe_ledseq.sv
// LED pattern sequencer: free-running tick divider, debounced step button,
// and four selectable patterns advanced either by tick or by button press.
module ubbe_ledseq
    import ubbe_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned DELAY      = 32'h0010_0000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [MODE_W-1:0]   mode,
    input  logic                run,
    input  logic                step,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam int unsigned LED_W = NUM_LEDS;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_d;
    mode_t            mode_in;
    mode_t            mode_q;
    scan_state_t      scan_q;
    scan_state_t      scan_d;
    logic [LED_W-1:0] led_d;
    logic [LED_W-1:0] shifted;
    logic             step_level;
    logic             step_rise;
    logic             press;
    logic             reload;
    logic             advance;

    ubbe_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (step),
        .dout    (step_level),
        .rise    (step_rise)
    );

    // A rise is only ever reported alongside a high level; qualify anyway.
    assign press   = step_rise & step_level;
    assign mode_in = mode_t'(mode);
    assign reload  = (mode_in != mode_q);
    assign advance = run ? tick : press;

    // Free-running divider, period DELAY+1.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_W'(DELAY)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Next pattern and scanner state; a reload beats a coincident advance.
    always_comb begin
        led_d   = led;
        scan_d  = scan_q;
        shifted = '0;
        if (reload) begin
            scan_d = SCAN_UP;
            case (mode_in)
                MODE_UP:   led_d = '0;
                MODE_DOWN: led_d = '1;
                default:   led_d = LED_W'(1);
            endcase
        end else if (advance) begin
            case (mode_q)
                MODE_UP:   led_d = led + LED_W'(1);
                MODE_DOWN: led_d = led - LED_W'(1);
                MODE_WALK: led_d = {led[LED_W-2:0], led[LED_W-1]};
                default: begin
                    if (scan_q == SCAN_UP) begin
                        shifted = led << 1;
                        if (shifted[LED_W-1]) begin
                            scan_d = SCAN_DOWN;
                        end
                    end else begin
                        shifted = led >> 1;
                        if (shifted[0]) begin
                            scan_d = SCAN_UP;
                        end
                    end
                    led_d = shifted;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick   <= 1'b0;
            mode_q <= MODE_UP;
            scan_q <= SCAN_UP;
            led    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick   <= tick_d;
            mode_q <= mode_in;
            scan_q <= scan_d;
            led    <= led_d;
        end
    end

endmodule
